// File: rtl/exc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_redirect_ctrl
// Brief    : WB-to-pre-IF flush/redirect sequencer (exception, ERET, refetch)
// Revision : 1.0  initial release
// ============================================================================
module exc_redirect_ctrl #(
    parameter logic [31:0] EXC_VEC    = 32'hbfc0_0380,
    parameter logic [31:0] REFILL_VEC = 32'hbfc0_0200,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ws_exc,
    input  logic             ws_exc_refill,
    input  logic             ws_eret,
    input  logic [31:0]      ws_epc,
    input  logic             ws_refetch,
    input  logic [31:0]      ws_pc,
    input  logic             fs_redirect_rdy,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic             evt_lost,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_target;
    logic [31:0]      w_new_target;
    logic             r_evt_lost;
    logic [CNT_W-1:0] r_cnt;
    logic             w_evt;
    logic             w_accept;

    assign w_evt    = ws_exc | ws_eret | ws_refetch;
    assign w_accept = (r_state == S_REDIRECT) && fs_redirect_rdy;

    // Priority: exception over ERET over refetch.
    always_comb begin
        w_new_target = ws_pc + 32'd4;
        if (ws_exc) begin
            w_new_target = ws_exc_refill ? REFILL_VEC : EXC_VEC;
        end else if (ws_eret) begin
            w_new_target = ws_epc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:     if (w_evt) w_next_state = S_FLUSH;
            S_FLUSH:    w_next_state = S_REDIRECT;
            S_REDIRECT: if (fs_redirect_rdy) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Target is only captured from IDLE, so an in-flight redirect cannot be disturbed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_target   <= 32'd0;
            r_evt_lost <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_evt) begin
                r_target <= w_new_target;
            end
            if ((r_state != S_IDLE) && w_evt) begin
                r_evt_lost <= 1'b1;
            end
            if (w_accept && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign flush          = (r_state == S_FLUSH);
    assign redirect_valid = (r_state == S_REDIRECT);
    assign busy           = (r_state != S_IDLE);
    assign redirect_pc    = r_target;
    assign evt_lost       = r_evt_lost;
    assign redirect_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_redirect_ctrl
// Brief    : Self-checking bench for exc_redirect_ctrl (directed + random)
// Revision : 1.0  initial release
// ============================================================================
module tb_exc_redirect_ctrl;

    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic             ws_exc, ws_exc_refill, ws_eret, ws_refetch, fs_redirect_rdy;
    logic [31:0]      ws_epc, ws_pc;
    logic             flush, redirect_valid, busy, evt_lost;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] redirect_cnt;

    int errors = 0;
    int checks = 0;

    // Timeline model: an accepted event at edge E flushes after E, redirects from
    // after E+1, and completes on the first edge >= E+2 that sees rdy.
    bit          m_busy;
    int          m_ev_edge;
    int          edge_n;
    logic [31:0] m_target;
    bit          m_lost;
    int          m_cnt;

    exc_redirect_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_exc          (ws_exc),
        .ws_exc_refill   (ws_exc_refill),
        .ws_eret         (ws_eret),
        .ws_epc          (ws_epc),
        .ws_refetch      (ws_refetch),
        .ws_pc           (ws_pc),
        .fs_redirect_rdy (fs_redirect_rdy),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .busy            (busy),
        .evt_lost        (evt_lost),
        .redirect_cnt    (redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ev_edge = 0; m_target = 32'd0; m_lost = 0; m_cnt = 0;
    endtask

    task automatic check_model();
        chk("flush",   {31'd0, flush},          {31'd0, m_busy && (edge_n == m_ev_edge)});
        chk("valid",   {31'd0, redirect_valid}, {31'd0, m_busy && (edge_n >= m_ev_edge + 1)});
        chk("busy",    {31'd0, busy},           {31'd0, m_busy});
        chk("pc",      redirect_pc,             m_target);
        chk("lost",    {31'd0, evt_lost},       {31'd0, m_lost});
        chk("cnt",     32'(redirect_cnt),       32'(m_cnt));
    endtask

    task automatic drive(input bit exc, input bit refill, input bit eret, input bit refetch,
                         input logic [31:0] epc, input logic [31:0] pc, input bit rdy);
        ws_exc = exc; ws_exc_refill = refill; ws_eret = eret; ws_refetch = refetch;
        ws_epc = epc; ws_pc = pc; fs_redirect_rdy = rdy;
    endtask

    task automatic cyc();
        bit evt;
        @(posedge clk);
        edge_n++;
        evt = ws_exc | ws_eret | ws_refetch;
        if (m_busy) begin
            if (evt) m_lost = 1;
            if ((edge_n >= m_ev_edge + 2) && fs_redirect_rdy) begin
                m_busy = 0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (evt) begin
            m_busy    = 1;
            m_ev_edge = edge_n;
            if (ws_exc)       m_target = ws_exc_refill ? 32'hbfc0_0200 : 32'hbfc0_0380;
            else if (ws_eret) m_target = ws_epc;
            else              m_target = ws_pc + 32'd4;
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input bit rdy);
        drive(0, 0, 0, 0, 32'd0, 32'd0, rdy);
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        resetn = 1'b0;
        idle(0);
        #1;
        check_model();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check_model();

        // Plain exception, rdy already high.
        drive(1, 0, 0, 0, 32'd0, 32'd0, 1);
        cyc();
        chk("t1_flush", {31'd0, flush}, 32'd1);
        idle(1);
        cyc();
        chk("t1_pc", redirect_pc, 32'hbfc0_0380);
        cyc();
        chk("t1_cnt", 32'(redirect_cnt), 32'd1);

        // All events together: refill exception wins, nothing else serviced.
        drive(1, 1, 1, 1, 32'h1111_1111, 32'h2222_2222, 1);
        cyc();
        idle(1);
        cyc();
        chk("t2_pc", redirect_pc, 32'hbfc0_0200);
        repeat (3) cyc();
        chk("t2_busy", {31'd0, busy}, 32'd0);

        // ERET with a stalled pre-IF.
        drive(0, 0, 1, 0, 32'h8000_1234, 32'd0, 0);
        cyc();
        idle(0);
        repeat (6) cyc();
        chk("t3_pc", redirect_pc, 32'h8000_1234);
        idle(1);
        cyc();

        // Refetch wrap-around.
        drive(0, 0, 0, 1, 32'd0, 32'hffff_fffc, 1);
        cyc();
        idle(1);
        cyc();
        chk("t4_pc", redirect_pc, 32'h0000_0000);
        cyc();

        // Event arriving during REDIRECT is dropped and flagged.
        drive(0, 0, 1, 0, 32'h0040_0000, 32'd0, 0);
        cyc();
        idle(0);
        cyc();
        drive(1, 0, 0, 0, 32'd0, 32'd0, 0);
        cyc();
        chk("t5_lost", {31'd0, evt_lost}, 32'd1);
        chk("t5_pc", redirect_pc, 32'h0040_0000);
        idle(1);
        cyc();
        chk("t5_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset while in REDIRECT.
        drive(0, 0, 1, 0, 32'h9abc_def0, 32'd0, 0);
        cyc();
        idle(0);
        cyc();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_valid", {31'd0, redirect_valid}, 32'd0);
        check_model();
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        cyc();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom, $urandom, $urandom_range(0, 2) != 0);
            cyc();
        end
        idle(1);
        repeat (3) cyc();

        // Drive the counter into saturation.
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            drive(1, 0, 0, 0, 32'd0, 32'd0, 1);
            cyc();
            idle(1);
            cyc();
            cyc();
        end
        chk("sat_cnt", 32'(redirect_cnt), 32'(CNT_MAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
